ysyx22040228_regfile_sb: RTL and testbench
==========================================

# ysyx22040228_regfile_sb

Parametrised multi-port integer register file with an integrated per-register scoreboard, for the dual-issue core. It provides NRD combinational read ports and NWR write-back ports with same-cycle write-to-read bypass. A per-register pending bit is set at issue and cleared at write-back, with flush support and a registered pending-count output. Each read port reports whether its operand is valid.

## Interface
- XLEN, 64, register data width
- NREG, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREG)
- NRD, 3, number of read ports (≥1)
- NWR, 2, number of write ports (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wen  in  NWR  per-port write enable
- waddr  in  NWR*AW  packed write addresses, port k at [k*AW +: AW]
- wdata  in  NWR*XLEN  packed write data
- ren  in  NRD  per-port read enable
- raddr  in  NRD*AW  packed read addresses
- rdata  out  NRD*XLEN  packed read data
- rrdy  out  NRD  operand-valid flag per read port
- alloc_en  in  1  issue stage marks alloc_addr as pending
- alloc_addr  in  AW  destination register being issued
- flush  in  1  synchronous clear of all pending bits (pipeline squash)
- pend_cnt  out  $clog2(NREG+1)  registered count of pending registers

## Operation
- Storage: regs[0..NREG-1] of XLEN bits; pend[0..NREG-1] of 1 bit.
- Register 0 is hardwired:
  - Writes to it are ignored.
  - Allocations to it are ignored.
  - Reads of it return 0 with rrdy=1.
- Write: for each k with wen[k] and waddr≠0, regs[waddr[k]] <= wdata[k].
  - If several ports target the same address in one cycle, the highest-index port wins.
- Pending update, evaluated in priority order for each register r≠0:
  - flush: pend[r] <= 0. flush overrides everything, including alloc_en in the same cycle.
  - else if alloc_en and alloc_addr==r: pend[r] <= 1. A new producer wins over a same-cycle write-back to r; the data is still written.
  - else if any wen[k] with waddr[k]==r: pend[r] <= 0.
  - else hold.
- Read port j, all combinational:
  - rst=1 or ren[j]=0: rdata=0, rrdy=0.
  - raddr[j]==0: rdata=0, rrdy=1.
  - A write hit this cycle (some wen[k] with waddr[k]==raddr[j]): rdata = wdata of the highest-index hitting port, rrdy=1.
  - Otherwise: rdata=regs[raddr[j]], rrdy=~pend[raddr[j]].
  - An alloc_en in the same cycle does not affect rrdy until the next cycle.
- pend_cnt: a register holding popcount(pend) after each edge.
  - Updated incrementally: +1 for a new set, −1 for each cleared bit, or 0 on flush.
  - Must always equal popcount(pend); the bench checks this every cycle.

## Timing
- Reset (async assert): all regs=0, all pend=0, pend_cnt=0.
  - rdata=0 and rrdy=0 while rst=1, independent of clk.
  - On deassert, operation starts at the first rising edge.
- Write latency: 0 cycles to the reading port via bypass; 1 cycle to the array.
- Pending set: visible on rrdy the cycle after alloc_en.
- Pending clear: visible the same cycle via bypass, and held from the next cycle.
- pend_cnt lags pend state by 0 cycles, since both update on the same edge.
- No back-pressure: every write is accepted every cycle.
- Allocating an already-pending register is legal. pend stays 1 and pend_cnt is unchanged.
- Write-back to a non-pending register is legal. Data is written and pend_cnt is unchanged (no underflow).
- Reset mid-operation: an in-flight write in the asserting cycle is discarded. All state is cleared immediately.

## Test plan
- Reset, then read all registers on every port → rdata=0 on every port. rrdy=1 only for port addresses where ren=1; pend_cnt=0.
- alloc_en x5. Next cycle read x5 → rrdy=0. Then wen[0], x5, 0xDEAD_BEEF → same cycle rdata=0xDEADBEEF, rrdy=1. Next cycle array read returns 0xDEADBEEF with rrdy=1, and pend_cnt returns to 0.
- Same-cycle wen[0] and wen[1] both to x7, with data 0x1 and 0x2 → bypass and subsequent read both return 0x2.
- Same cycle: alloc x9 and write-back x9 = 0x55 → next cycle read x9 gives rdata=0x55, rrdy=0, pend_cnt=1.
- Allocate x1..x4 over four cycles (pend_cnt=4), then assert flush together with alloc x6 → next cycle pend_cnt=0 and all rrdy=1.
- Write x0 = 0xFFFF and alloc x0 → reads of x0 return 0, rrdy=1, pend_cnt=0. Assert rst asynchronously mid-cycle during a write → outputs drop to 0 immediately, and the written register reads 0 after release.

Source files
------------

// File: rtl/ysyx22040228_regfile_sb.sv
// ysyx22040228_regfile_sb: multi-port register file with per-register pending scoreboard
module ysyx22040228_regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD = 3,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD-1:0]      ren,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rrdy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [CW-1:0]       pend_cnt
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend, pend_n, wb;
  logic [CW-1:0] sets, clrs;
  // registers targeted by any write-back port this cycle
  always_comb begin
    wb = '0;
    for (int k = 0; k < NWR; k++)
      if (wen[k]) wb[waddr[k*AW +: AW]] = 1'b1;
  end
  // next pending state: flush, then new producer, then write-back clear
  always_comb begin
    pend_n = '0;
    sets = '0;
    clrs = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_n[r] = (r == 0) ? 1'b0 :
                  flush ? 1'b0 :
                  (alloc_en && alloc_addr == AW'(r)) ? 1'b1 :
                  wb[r] ? 1'b0 : pend[r];
      sets = sets + CW'(pend_n[r] & ~pend[r]);
      clrs = clrs + CW'(pend[r] & ~pend_n[r]);
    end
  end
  // array write (highest port wins), pending bits and incremental count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      pend <= '0;
      pend_cnt <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wen[k] && waddr[k*AW +: AW] != '0) regs[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
      pend <= pend_n;
      pend_cnt <= flush ? '0 : pend_cnt + sets - clrs;
    end
  // read ports with same-cycle write-back bypass
  always_comb begin
    rdata = '0;
    rrdy = '0;
    for (int j = 0; j < NRD; j++)
      if (!rst && ren[j]) begin
        if (raddr[j*AW +: AW] == '0) rrdy[j] = 1'b1;
        else begin
          rdata[j*XLEN +: XLEN] = regs[raddr[j*AW +: AW]];
          rrdy[j] = ~pend[raddr[j*AW +: AW]];
          for (int k = 0; k < NWR; k++)
            if (wen[k] && waddr[k*AW +: AW] == raddr[j*AW +: AW]) begin
              rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
              rrdy[j] = 1'b1;
            end
        end
      end
  end
endmodule

// File: tb/tb_ysyx22040228_regfile_sb.sv
// tb_ysyx22040228_regfile_sb: directed and randomized checks against an array model
module tb_ysyx22040228_regfile_sb;
  logic clk = 0, rst = 1;
  logic [1:0] wen;
  logic [9:0] waddr;
  logic [127:0] wdata;
  logic [2:0] ren;
  logic [14:0] raddr;
  logic [191:0] rdata;
  logic [2:0] rrdy;
  logic alloc_en, flush;
  logic [4:0] alloc_addr;
  logic [5:0] pend_cnt;
  int cmp = 0, err = 0;
  logic [63:0] mregs [32];
  bit mpend [32];

  ysyx22040228_regfile_sb dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rrdy(rrdy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout cmp=%0d", cmp);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    cmp++;
    assert (o === e) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic int popc();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(mpend[r]);
    return n;
  endfunction

  task automatic idle();
    wen = 0; waddr = 0; wdata = 0; ren = 0; raddr = 0;
    alloc_en = 0; alloc_addr = 0; flush = 0;
  endtask

  task automatic setw(input int k, input logic [4:0] a, input logic [63:0] d);
    wen[k] = 1; waddr[k*5 +: 5] = a; wdata[k*64 +: 64] = d;
  endtask

  task automatic setr(input int j, input logic [4:0] a);
    ren[j] = 1; raddr[j*5 +: 5] = a;
  endtask

  task automatic alloc(input logic [4:0] a);
    alloc_en = 1; alloc_addr = a;
  endtask

  task automatic look();
    #1;
    for (int j = 0; j < 3; j++) begin
      logic [63:0] ed;
      logic er;
      logic [4:0] a;
      a = raddr[j*5 +: 5];
      ed = 0; er = 0;
      if (!rst && ren[j]) begin
        if (a == 0) er = 1;
        else begin
          ed = mregs[a]; er = !mpend[a];
          for (int k = 0; k < 2; k++)
            if (wen[k] && waddr[k*5 +: 5] == a) begin ed = wdata[k*64 +: 64]; er = 1; end
        end
      end
      chk($sformatf("rdata%0d", j), rdata[j*64 +: 64], ed);
      chk($sformatf("rrdy%0d", j), {63'b0, rrdy[j]}, {63'b0, er});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++)
        if (wen[k] && waddr[k*5 +: 5] != 0) mregs[waddr[k*5 +: 5]] = wdata[k*64 +: 64];
      if (flush) for (int r = 0; r < 32; r++) mpend[r] = 0;
      else begin
        for (int k = 0; k < 2; k++) if (wen[k]) mpend[waddr[k*5 +: 5]] = 0;
        if (alloc_en && alloc_addr != 0) mpend[alloc_addr] = 1;
      end
    end
    #1;
    chk("pend_cnt", 64'(pend_cnt), 64'(popc()));
    @(negedge clk);
  endtask

  task automatic mclear();
    for (int r = 0; r < 32; r++) begin mregs[r] = 0; mpend[r] = 0; end
  endtask

  initial begin
    idle();
    mclear();
    #3;
    chk("rst_rdata", {63'b0, |rdata}, 0);
    chk("rst_rrdy", {61'b0, rrdy}, 0);
    @(negedge clk);
    rst = 0;
    for (int r = 0; r < 32; r++) begin
      idle();
      ren = 3'(r);
      raddr = {3{5'(r)}};
      look();
      chk("init_rrdy", {61'b0, rrdy}, {61'b0, ren});
      tick();
    end
    chk("init_cnt", 64'(pend_cnt), 0);
    idle(); alloc(5); look(); tick();
    chk("alloc5_cnt", 64'(pend_cnt), 1);
    idle(); setr(0, 5); look();
    chk("x5_pending", {63'b0, rrdy[0]}, 0);
    tick();
    idle(); setr(0, 5); setw(0, 5, 64'hDEAD_BEEF); look();
    chk("x5_bypass", rdata[63:0], 64'hDEAD_BEEF);
    chk("x5_bypass_rdy", {63'b0, rrdy[0]}, 1);
    tick();
    idle(); setr(0, 5); look();
    chk("x5_array", rdata[63:0], 64'hDEAD_BEEF);
    chk("x5_array_rdy", {63'b0, rrdy[0]}, 1);
    chk("x5_cnt", 64'(pend_cnt), 0);
    tick();
    idle(); setw(0, 7, 1); setw(1, 7, 2); setr(1, 7); look();
    chk("x7_bypass", rdata[127:64], 2);
    tick();
    idle(); setr(1, 7); look();
    chk("x7_array", rdata[127:64], 2);
    tick();
    idle(); alloc(9); setw(0, 9, 64'h55); look(); tick();
    chk("x9_cnt", 64'(pend_cnt), 1);
    idle(); setr(2, 9); look();
    chk("x9_data", rdata[191:128], 64'h55);
    chk("x9_rdy", {63'b0, rrdy[2]}, 0);
    tick();
    idle(); setw(1, 9, 64'h55); look(); tick();
    for (int a = 1; a <= 4; a++) begin idle(); alloc(5'(a)); look(); tick(); end
    chk("alloc4_cnt", 64'(pend_cnt), 4);
    idle(); flush = 1; alloc(6); look(); tick();
    chk("flush_cnt", 64'(pend_cnt), 0);
    idle(); setr(0, 1); setr(1, 4); setr(2, 6); look();
    chk("flush_rrdy", {61'b0, rrdy}, 7);
    tick();
    idle(); setw(0, 0, 64'hFFFF); alloc(0); setr(0, 0); look();
    chk("x0_data", rdata[63:0], 0);
    chk("x0_rdy", {63'b0, rrdy[0]}, 1);
    tick();
    chk("x0_cnt", 64'(pend_cnt), 0);
    idle(); setr(0, 0); look(); tick();
    idle(); alloc(10); look(); tick();
    idle(); setw(0, 10, 64'h1234); setr(0, 10); setr(1, 3);
    #2 rst = 1;
    #1;
    chk("async_rdata", {63'b0, |rdata}, 0);
    chk("async_rrdy", {61'b0, rrdy}, 0);
    chk("async_cnt", 64'(pend_cnt), 0);
    mclear();
    @(negedge clk);
    rst = 0;
    idle(); setr(0, 10); look();
    chk("x10_after_rst", rdata[63:0], 0);
    chk("x10_rdy_after_rst", {63'b0, rrdy[0]}, 1);
    tick();
    for (int i = 0; i < 400; i++) begin
      idle();
      wen = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        waddr[k*5 +: 5] = 5'($urandom_range(0, 7));
        wdata[k*64 +: 64] = {$urandom, $urandom};
      end
      ren = 3'($urandom);
      for (int j = 0; j < 3; j++) raddr[j*5 +: 5] = 5'($urandom_range(0, 7));
      alloc_en = 1'($urandom);
      alloc_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      look();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
